// File: rtl/conv_mul_pipe.sv
// Pipelined DIN0 x DIN1 multiplier with clock enable and a NUM_STAGE-deep valid/data pipeline.
// Define CONV_MUL_PIPE_ACC_EN to turn dout into a wrapping accumulator cleared by acc_clr.
`timescale 1ns/1ps
module conv_mul_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 8,
  parameter int DOUT_WIDTH  = 24,
  parameter int NUM_STAGE   = 3,
  parameter int SIGNED_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic [PW-1:0]         w_prod;
  logic [DOUT_WIDTH-1:0] w_prod_map;
  logic [DOUT_WIDTH-1:0] w_last_data;
  logic                  w_last_vld;
  logic                  w_last_clr;
  logic [DOUT_WIDTH-1:0] w_next_dout;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic                  r_out_valid;

  // Full-width product: both operands are widened to PW before multiplying.
  generate
    if (SIGNED_MODE != 0) begin : g_signed
      logic signed [PW-1:0] w_a;
      logic signed [PW-1:0] w_b;
      logic signed [PW-1:0] w_prod_s;
      assign w_a      = PW'($signed(din0));
      assign w_b      = PW'($signed(din1));
      assign w_prod_s = w_a * w_b;
      assign w_prod   = w_prod_s;
    end else begin : g_unsigned
      assign w_prod = {{DIN1_WIDTH{1'b0}}, din0} * {{DIN0_WIDTH{1'b0}}, din1};
    end
  endgenerate

  generate
    if (DOUT_WIDTH > PW) begin : g_extend
      logic w_ext_bit;
      assign w_ext_bit  = (SIGNED_MODE != 0) ? w_prod[PW-1] : 1'b0;
      assign w_prod_map = {{(DOUT_WIDTH-PW){w_ext_bit}}, w_prod};
    end else if (DOUT_WIDTH == PW) begin : g_same
      assign w_prod_map = w_prod;
    end else begin : g_truncate
      // Modulo truncation: the discarded high product bits are intentionally dropped.
      logic [PW-DOUT_WIDTH-1:0] w_unused_hi;
      assign w_unused_hi = w_prod[PW-1:DOUT_WIDTH];
      assign w_prod_map  = w_prod[DOUT_WIDTH-1:0];
    end
  endgenerate

  // Stages 1..NUM_STAGE-1 precede the output register; NUM_STAGE=1 feeds it directly.
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign w_last_data = w_prod_map;
      assign w_last_vld  = in_valid;
      assign w_last_clr  = acc_clr;
    end else begin : g_pipe
      logic [DOUT_WIDTH-1:0] r_data [1:NUM_STAGE-1];
      logic [NUM_STAGE-1:1]  r_vld;
      logic [NUM_STAGE-1:1]  r_clr;

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 1; i < NUM_STAGE; i++) begin
            r_data[i] <= '0;
          end
          r_vld <= '0;
          r_clr <= '0;
        end else if (ce) begin
          r_data[1] <= w_prod_map;
          r_vld[1]  <= in_valid;
          r_clr[1]  <= acc_clr;
          for (int i = 2; i < NUM_STAGE; i++) begin
            r_data[i] <= r_data[i-1];
            r_vld[i]  <= r_vld[i-1];
            r_clr[i]  <= r_clr[i-1];
          end
        end
      end

      assign w_last_data = r_data[NUM_STAGE-1];
      assign w_last_vld  = r_vld[NUM_STAGE-1];
      assign w_last_clr  = r_clr[NUM_STAGE-1];
    end
  endgenerate

`ifdef CONV_MUL_PIPE_ACC_EN
  assign w_next_dout = (w_last_clr ? '0 : r_dout) + w_last_data;
`else
  logic w_unused_clr;
  assign w_unused_clr = w_last_clr;
  assign w_next_dout  = w_last_data;
`endif

  // Output register doubles as the accumulator; it only moves on a valid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_last_vld;
      if (w_last_vld) begin
        r_dout <= w_next_dout;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule

// File: doc/conv_mul_pipe.md
CONV_MUL_PIPE -- requirements
Module: conv_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 16, width of operand din0 (2..32).
REQ-002 SHALL have parameter DIN1_WIDTH, default 8, width of operand din1 (2..32).
REQ-003 SHALL have parameter DOUT_WIDTH, default 24, width of dout and accumulator (2..64).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline latency in enabled cycles (1..4).
REQ-005 SHALL have parameter SIGNED_MODE, default 1; 1 = signed operands, 0 = unsigned operands.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port ce, input, 1, clock enable; 0 freezes all state.
REQ-009 SHALL have port in_valid, input, 1, din0/din1/acc_clr qualify this cycle.
REQ-010 SHALL have port din0, input, DIN0_WIDTH, multiplicand.
REQ-011 SHALL have port din1, input, DIN1_WIDTH, multiplier.
REQ-012 SHALL have port acc_clr, input, 1, start-new-sum marker for this sample (ignored without CONV_MUL_PIPE_ACC_EN).
REQ-013 SHALL have port out_valid, output, 1, dout carries a new result this cycle.
REQ-014 SHALL have port dout, output, DOUT_WIDTH, product or running sum.

Function
REQ-015 SHALL form the full product at DIN0_WIDTH+DIN1_WIDTH bits, signed or unsigned per SIGNED_MODE.
REQ-016 SHALL map the product to DOUT_WIDTH by sign/zero-extension if narrower, or by keeping the LSBs (modulo truncation, no saturation) if wider.
REQ-017 SHALL present the result of a sample accepted with in_valid=1, ce=1 on dout with out_valid=1 exactly NUM_STAGE ce=1 cycles later.
REQ-018 SHALL carry in_valid (and acc_clr) through a NUM_STAGE-deep valid shift register in lockstep with the data.
REQ-019 SHALL, when ce=0, hold every pipeline register, valid bit, accumulator, dout and out_valid unchanged; no sample is lost or duplicated across stalls.
REQ-020 SHALL accept back-to-back samples every ce=1 cycle (throughput 1/cycle); bubbles (in_valid=0) propagate as out_valid=0.
REQ-021 SHALL keep dout at its last value when out_valid=0 (no output update on bubbles).
REQ-022 SHALL register the output; NUM_STAGE=1 places the single register at the output with a combinational multiply before it.
REQ-023 SHALL have no combinational path from any input to out_valid or dout.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, clear all pipeline data, valid bits, accumulator, dout=0 and out_valid=0 regardless of ce.
REQ-025 SHALL discard in-flight samples on reset mid-operation; first out_valid after reset release is for the first sample accepted after release.
REQ-026 SHALL give reset priority over ce and in_valid in the same cycle.

Configuration
REQ-027 SHALL recognise macro CONV_MUL_PIPE_ACC_EN.
REQ-028 SHALL, with CONV_MUL_PIPE_ACC_EN defined, make dout a DOUT_WIDTH accumulator updated in the final stage: for an output-valid slot, acc <= (delayed acc_clr ? 0 : acc) + mapped product; dout = acc.
REQ-029 SHALL, with the macro defined, wrap the accumulator modulo 2^DOUT_WIDTH on overflow, leave it unchanged on bubbles and stalls, and keep latency NUM_STAGE.
REQ-030 SHALL, without the macro, output the mapped product only, ignore acc_clr, and instantiate no accumulator register.

Verification
REQ-031 SHALL cover: NUM_STAGE=3, SIGNED_MODE=1, din0=-3 (0xFFFD), din1=5, in_valid=1 pulse -> out_valid=1 three cycles later, dout=0xFFFFF1 (-15).
REQ-032 SHALL cover: SIGNED_MODE=0, din0=0xFFFF, din1=0xFF -> dout=0xFEFF01.
REQ-033 SHALL cover: 4 back-to-back samples, ce=0 for 2 cycles after the second -> 4 results in order, out_valid gaps exactly 2 cycles, values unchanged.
REQ-034 SHALL cover: reset asserted with 2 samples in flight -> out_valid never asserts for them, dout=0 next cycle.
REQ-035 SHALL cover (ACC_EN): samples (2,3) acc_clr=1, (4,5), bubble, (1,1) -> dout sequence 6, 26, 27; then (1,1) acc_clr=1 -> 1.
REQ-036 SHALL cover (ACC_EN, DOUT_WIDTH=24): acc=0x7FFFFF then add 1 -> dout=0x800000 (wrap, no saturation).
